// File: rtl/ipml_prefetch_rd_ctrl_v2.sv
// Read-side prefetch controller: issues RAM reads ahead of demand and hides the
// RAM read latency behind a small circular register buffer feeding a valid/ready consumer.
module ipml_prefetch_rd_ctrl_v2 #(
  parameter int c_DATA_WIDTH     = 32,
  parameter int c_RAM_LATENCY    = 1,
  parameter int c_PREFETCH_DEPTH = 4,
  parameter int c_CNT_WIDTH      = 5
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    flush,
  input  logic                    fifo_empty,
  output logic                    ram_rd_en,
  input  logic [c_DATA_WIDTH-1:0] ram_rd_data,
  output logic [c_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_vld,
  input  logic                    rd_en,
  output logic [c_CNT_WIDTH-1:0]  buf_level
);

  // Consumer handshake: a word transfers on every cycle where rd_vld and rd_en are both 1;
  // rd_data is held stable while rd_vld=1 until that transfer happens.

  localparam int PTR_W = (c_PREFETCH_DEPTH > 1) ? $clog2(c_PREFETCH_DEPTH) : 1;
  localparam int SUM_W = c_CNT_WIDTH + 2;
  localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(c_PREFETCH_DEPTH - 1);
  localparam logic [SUM_W-1:0]       DEPTH_S  = SUM_W'(c_PREFETCH_DEPTH);
  localparam logic [c_CNT_WIDTH-1:0] DEPTH_C  = c_CNT_WIDTH'(c_PREFETCH_DEPTH);

  logic [c_RAM_LATENCY-1:0] vld_sr;
  logic [c_DATA_WIDTH-1:0]  mem [c_PREFETCH_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [SUM_W-1:0]         inflight;
  logic                     pop;
  logic                     wr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop    = rd_vld & rd_en;
  assign wr     = vld_sr[c_RAM_LATENCY-1];
  assign rd_vld = (buf_level != '0);
  assign rd_data = mem[head];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < c_RAM_LATENCY; i++) begin
      inflight = inflight + SUM_W'(vld_sr[i]);
    end
  end

  // A pop frees a slot in the same cycle, so issue may continue at full occupancy.
  assign ram_rd_en = ~fifo_empty & ~flush & ~rd_rst &
                     (((SUM_W'(buf_level) + inflight) < DEPTH_S) | pop);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      vld_sr    <= '0;
      head      <= '0;
      tail      <= '0;
      buf_level <= '0;
      for (int i = 0; i < c_PREFETCH_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      vld_sr    <= '0;
      head      <= '0;
      tail      <= '0;
      buf_level <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | c_RAM_LATENCY'(ram_rd_en);
      if (wr) begin
        mem[tail] <= ram_rd_data;
        tail      <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      case ({wr, pop})
        2'b10:   buf_level <= buf_level + c_CNT_WIDTH'(1);
        2'b01:   buf_level <= buf_level - c_CNT_WIDTH'(1);
        default: buf_level <= buf_level;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(wr && !pop && buf_level == DEPTH_C));

endmodule

// File: tb/tb_ipml_prefetch_rd_ctrl_v2.sv
// Bench for ipml_prefetch_rd_ctrl_v2: a latency-2/depth-4 instance driven by a cycle table
// and a latency-3/depth-5 instance for flush and random-backpressure ordering.
module tb_ipml_prefetch_rd_ctrl_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: latency 2, depth 4
  logic        rst_a, flush_a, rd_en_a, ram_rd_en_a, rd_vld_a, fifo_empty_a;
  logic [31:0] ram_rd_data_a, rd_data_a;
  logic [4:0]  buf_level_a;
  logic [31:0] core_mem_a [0:63];
  logic [31:0] pipe_a [0:1];
  int          core_cnt_a = 0;
  int          core_rp_a  = 0;

  // Instance B: latency 3, depth 5
  logic        rst_b, flush_b, rd_en_b, ram_rd_en_b, rd_vld_b, fifo_empty_b;
  logic [31:0] ram_rd_data_b, rd_data_b;
  logic [4:0]  buf_level_b;
  logic [31:0] core_mem_b [0:2047];
  logic [31:0] pipe_b [0:2];
  int          core_cnt_b = 0;
  int          core_rp_b  = 0;

  logic [31:0] exp_q[$];
  logic        mon_b = 1'b0;

  ipml_prefetch_rd_ctrl_v2 #(
    .c_DATA_WIDTH(32), .c_RAM_LATENCY(2), .c_PREFETCH_DEPTH(4), .c_CNT_WIDTH(5)
  ) dut_a (
    .rd_clk(clk), .rd_rst(rst_a), .flush(flush_a), .fifo_empty(fifo_empty_a),
    .ram_rd_en(ram_rd_en_a), .ram_rd_data(ram_rd_data_a), .rd_data(rd_data_a),
    .rd_vld(rd_vld_a), .rd_en(rd_en_a), .buf_level(buf_level_a)
  );

  ipml_prefetch_rd_ctrl_v2 #(
    .c_DATA_WIDTH(32), .c_RAM_LATENCY(3), .c_PREFETCH_DEPTH(5), .c_CNT_WIDTH(5)
  ) dut_b (
    .rd_clk(clk), .rd_rst(rst_b), .flush(flush_b), .fifo_empty(fifo_empty_b),
    .ram_rd_en(ram_rd_en_b), .ram_rd_data(ram_rd_data_b), .rd_data(rd_data_b),
    .rd_vld(rd_vld_b), .rd_en(rd_en_b), .buf_level(buf_level_b)
  );

  // Raw core models: pop on ram_rd_en, data delayed by the RAM latency
  assign fifo_empty_a  = (core_rp_a >= core_cnt_a);
  assign ram_rd_data_a = pipe_a[1];
  always @(posedge clk) begin
    pipe_a[0] <= core_mem_a[core_rp_a];
    pipe_a[1] <= pipe_a[0];
    if (ram_rd_en_a) core_rp_a <= core_rp_a + 1;
  end

  assign fifo_empty_b  = (core_rp_b >= core_cnt_b);
  assign ram_rd_data_b = pipe_b[2];
  always @(posedge clk) begin
    pipe_b[0] <= core_mem_b[core_rp_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (ram_rd_en_b) core_rp_b <= core_rp_b + 1;
  end

  typedef struct {
    logic        rd_en;
    logic        exp_en;
    logic        exp_vld;
    logic [4:0]  exp_lvl;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tab [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic en);
    @(posedge clk);
    #1;
    rd_en_a = en;
    @(negedge clk);
  endtask

  task automatic step_b(input logic en, input logic fl);
    logic [31:0] exp_w;
    @(posedge clk);
    #1;
    rd_en_b = en;
    flush_b = fl;
    @(negedge clk);
    if (mon_b) begin
      tests++;
      if (buf_level_b > 5'd5) begin
        fails++;
        $display("FAIL b_level_max: got %0d required <= 5", buf_level_b);
      end
      if (rd_vld_b && rd_en_b) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b_extra_word: got %h required none", rd_data_b);
        end else begin
          exp_w = exp_q.pop_front();
          if (rd_data_b !== exp_w) begin
            fails++;
            $display("FAIL b_order: got %h required %h", rd_data_b, exp_w);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_next;
    int          pulses;

    rst_a = 1'b1; flush_a = 1'b0; rd_en_a = 1'b0;
    rst_b = 1'b1; flush_b = 1'b0; rd_en_b = 1'b0;
    for (int i = 0; i < 64; i++) core_mem_a[i] = '0;
    for (int i = 0; i < 10; i++) core_mem_a[i] = 32'hA0 + 32'(i);
    for (int i = 10; i < 20; i++) core_mem_a[i] = 32'hC0 + 32'(i - 10);
    for (int i = 0; i < 2048; i++) core_mem_b[i] = 32'h1000 + 32'(i);
    core_cnt_a = 10;
    core_cnt_b = 8;

    //           rd_en en vld lvl chk data
    tab[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h00};
    tab[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h00};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h00};
    tab[3]  = '{1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 32'hA0};
    tab[4]  = '{1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 32'hA0};
    tab[5]  = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 32'hA0};
    tab[6]  = '{1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 32'hA0};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 32'hA0};
    tab[8]  = '{1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 32'hA0};
    tab[9]  = '{1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 32'hA1};
    tab[10] = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 32'hA2};
    tab[11] = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 32'hA3};
    tab[12] = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 32'hA4};
    tab[13] = '{1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 32'hA5};
    tab[14] = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'hA6};
    tab[15] = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'hA7};
    tab[16] = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 32'hA8};
    tab[17] = '{1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 32'hA9};
    tab[18] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h00};

    // Reset held with a non-empty core
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_ram_rd_en", 32'(ram_rd_en_a), 32'd0);
    check("a_rst_rd_vld",    32'(rd_vld_a),    32'd0);
    check("a_rst_level",     32'(buf_level_a), 32'd0);
    check("a_rst_rd_data",   rd_data_a,        32'd0);
    check("b_rst_ram_rd_en", 32'(ram_rd_en_b), 32'd0);

    // Latency, backpressure fill and full-rate streaming
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rd_en_a = tab[i].rd_en;
      @(negedge clk);
      check($sformatf("a_v%0d_ram_rd_en", i), 32'(ram_rd_en_a), 32'(tab[i].exp_en));
      check($sformatf("a_v%0d_rd_vld", i),    32'(rd_vld_a),    32'(tab[i].exp_vld));
      check($sformatf("a_v%0d_level", i),     32'(buf_level_a), 32'(tab[i].exp_lvl));
      if (tab[i].chk_data) check($sformatf("a_v%0d_rd_data", i), rd_data_a, tab[i].exp_data);
    end

    // Mid-stream reset
    core_cnt_a = 20;
    for (int k = 0; k < 20 && !rd_vld_a; k++) step_a(1'b1);
    check("a_restream_vld", 32'(rd_vld_a), 32'd1);
    step_a(1'b1);
    step_a(1'b1);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    check("a_mid_rst_rd_vld",    32'(rd_vld_a),    32'd0);
    check("a_mid_rst_level",     32'(buf_level_a), 32'd0);
    check("a_mid_rst_ram_rd_en", 32'(ram_rd_en_a), 32'd0);
    check("a_mid_rst_rd_data",   rd_data_a,        32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_a   = 1'b0;
    rd_en_a = 1'b0;
    exp_next = core_mem_a[core_rp_a];
    @(negedge clk);
    check("a_post_rst_ram_rd_en", 32'(ram_rd_en_a), 32'd1);
    for (int k = 0; k < 10 && !rd_vld_a; k++) step_a(1'b0);
    check("a_post_rst_vld",  32'(rd_vld_a), 32'd1);
    check("a_post_rst_data", rd_data_a,     exp_next);

    // Flush with three buffered words and two reads in flight
    @(posedge clk);
    #1;
    rst_b  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      rd_en_b = 1'b0;
      flush_b = (c == 6);
      @(negedge clk);
      if (ram_rd_en_b) pulses++;
      if (c == 6) begin
        check("b_pre_flush_level",  32'(buf_level_b), 32'd3);
        check("b_flush_ram_rd_en",  32'(ram_rd_en_b), 32'd0);
      end
    end
    check("b_fill_pulses", 32'(pulses), 32'd5);
    exp_q.push_back(32'h1005);
    exp_q.push_back(32'h1006);
    exp_q.push_back(32'h1007);
    mon_b = 1'b1;
    step_b(1'b1, 1'b0);
    check("b_post_flush_vld",   32'(rd_vld_b),    32'd0);
    check("b_post_flush_level", 32'(buf_level_b), 32'd0);
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step_b(1'b1, 1'b0);
    check("b_flush_drain", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 10; k++) step_b(1'b1, 1'b0);

    // Random backpressure, 1000 words through the depth-5 wrap
    for (int i = 0; i < 1000; i++) begin
      core_mem_b[core_cnt_b + i] = 32'h5A00_0000 + 32'(i * 3);
      exp_q.push_back(32'h5A00_0000 + 32'(i * 3));
    end
    core_cnt_b = core_cnt_b + 1000;
    for (int k = 0; k < 8000 && exp_q.size() > 0; k++) begin
      step_b(1'($urandom_range(0, 1)), 1'b0);
    end
    check("b_rand_all_words", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 10; k++) step_b(1'b1, 1'b0);
    check("b_rand_end_level", 32'(buf_level_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
